// File: rtl/multi_delay_wakeup.sv
// Multi-channel delay/wakeup timer: per-channel one-shot or periodic countdown,
// with pending wakeups round-robin arbitrated onto a single registered valid/ready port.
module multi_delay_wakeup #(
  parameter  int CH    = 4,
  parameter  int DLY_W = 8,
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [DLY_W-1:0] load_dly,
  input  logic             load_periodic,
  input  logic [CH-1:0]    cancel,
  output logic             wake_valid,
  output logic [CH_W-1:0]  wake_ch,
  input  logic             wake_ready,
  output logic [CH-1:0]    busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_PEND  = 2'd2;
  localparam logic [DLY_W-1:0] DLY_ONE = {{(DLY_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state  [CH];
  logic [DLY_W-1:0] r_cnt    [CH];
  logic [DLY_W-1:0] r_reload [CH];
  logic [CH-1:0]    r_per;
  logic [CH-1:0]    r_busy;
  logic             r_wake_valid;
  logic [CH_W-1:0]  r_wake_ch;
  logic [CH_W-1:0]  r_last;

  logic [1:0]       w_state_nxt  [CH];
  logic [DLY_W-1:0] w_cnt_nxt    [CH];
  logic [DLY_W-1:0] w_reload_nxt [CH];
  logic [CH-1:0]    w_per_nxt;
  logic             w_load_pend;
  logic             w_load_fire;
  logic             w_accept;
  logic [DLY_W-1:0] w_dly_eff;
  logic             w_gnt_any;
  logic [CH_W-1:0]  w_gnt_ch;
  logic [CH_W-1:0]  w_idx;

  // Loads are refused only while the addressed channel holds a pending wakeup
  always_comb begin
    w_load_pend = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (load_ch == CH_W'(i)) begin
        w_load_pend = (r_state[i] == S_PEND);
      end else begin
        w_load_pend = w_load_pend;
      end
    end
  end

  assign load_ready  = rst & ~w_load_pend;
  assign w_load_fire = load_valid & load_ready;
  assign w_accept    = r_wake_valid & wake_ready;
  assign w_dly_eff   = (load_dly == {DLY_W{1'b0}}) ? DLY_ONE : load_dly;

  // Per-channel next state; priority is cancel > load > accept > countdown
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_state_nxt[i]  = r_state[i];
      w_cnt_nxt[i]    = r_cnt[i];
      w_reload_nxt[i] = r_reload[i];
      w_per_nxt[i]    = r_per[i];
      if (cancel[i]) begin
        w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i]   = {DLY_W{1'b0}};
      end else if (w_load_fire && (load_ch == CH_W'(i))) begin
        w_state_nxt[i]  = S_COUNT;
        w_cnt_nxt[i]    = w_dly_eff;
        w_reload_nxt[i] = w_dly_eff;
        w_per_nxt[i]    = load_periodic;
      end else if (w_accept && (r_wake_ch == CH_W'(i))) begin
        if (r_per[i]) begin
          w_state_nxt[i] = S_COUNT;
          w_cnt_nxt[i]   = r_reload[i];
        end else begin
          w_state_nxt[i] = S_IDLE;
        end
      end else if (r_state[i] == S_COUNT) begin
        if (r_cnt[i] == DLY_ONE) begin
          w_state_nxt[i] = S_PEND;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] - DLY_ONE;
        end
      end else begin
        w_state_nxt[i] = r_state[i];
      end
    end
  end

  // Round-robin search over next-cycle PEND channels; descending loop keeps the nearest hit
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_ch  = {CH_W{1'b0}};
    w_idx     = {CH_W{1'b0}};
    for (int k = CH; k >= 1; k--) begin
      w_idx = CH_W'((int'(r_last) + k) % CH);
      if (w_state_nxt[w_idx] == S_PEND) begin
        w_gnt_any = 1'b1;
        w_gnt_ch  = w_idx;
      end else begin
        w_gnt_any = w_gnt_any;
      end
    end
  end

  // Channel state, wake port lock and arbitration pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        r_state[i]  <= S_IDLE;
        r_cnt[i]    <= {DLY_W{1'b0}};
        r_reload[i] <= {DLY_W{1'b0}};
      end
      r_per        <= {CH{1'b0}};
      r_busy       <= {CH{1'b0}};
      r_wake_valid <= 1'b0;
      r_wake_ch    <= {CH_W{1'b0}};
      r_last       <= CH_W'(CH - 1);
    end else begin
      for (int i = 0; i < CH; i++) begin
        r_state[i]  <= w_state_nxt[i];
        r_cnt[i]    <= w_cnt_nxt[i];
        r_reload[i] <= w_reload_nxt[i];
        r_busy[i]   <= (w_state_nxt[i] != S_IDLE);
      end
      r_per <= w_per_nxt;
      if (w_accept) begin
        r_last <= r_wake_ch;
      end else begin
        r_last <= r_last;
      end
      // A held wakeup stays locked until accepted or its channel is cancelled
      if (r_wake_valid) begin
        if (w_accept || cancel[r_wake_ch]) begin
          r_wake_valid <= 1'b0;
        end else begin
          r_wake_valid <= 1'b1;
        end
      end else if (w_gnt_any) begin
        r_wake_valid <= 1'b1;
        r_wake_ch    <= w_gnt_ch;
      end else begin
        r_wake_valid <= 1'b0;
      end
    end
  end

  assign wake_valid = r_wake_valid;
  assign wake_ch    = r_wake_ch;
  assign busy       = r_busy;

endmodule

// File: tb/tb_multi_delay_wakeup.sv
// Scoreboard bench for multi_delay_wakeup: directed arming sequences push expected
// (channel, cycle) wakeups; a monitor pops and compares on every wake handshake.
module tb_multi_delay_wakeup;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [1:0] load_ch;
  logic [7:0] load_dly;
  logic       load_periodic;
  logic [3:0] cancel;
  logic       wake_valid;
  logic [1:0] wake_ch;
  logic       wake_ready;
  logic [3:0] busy;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int exp_ch  [$];
  int exp_cyc [$];

  multi_delay_wakeup dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_ch       (load_ch),
    .load_dly      (load_dly),
    .load_periodic (load_periodic),
    .cancel        (cancel),
    .wake_valid    (wake_valid),
    .wake_ch       (wake_ch),
    .wake_ready    (wake_ready),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int ch, input int c);
    exp_ch.push_back(ch);
    exp_cyc.push_back(c);
  endtask

  // Issue one load; t returns the cycle count just after the accepting edge
  task automatic arm(input int ch, input int dly, input bit per, output int t);
    load_valid    = 1'b1;
    load_ch       = ch[1:0];
    load_dly      = dly[7:0];
    load_periodic = per;
    @(negedge clk);
    chk("load_ready_arm", int'(load_ready), 1);
    tick();
    load_valid = 1'b0;
    t = cyc;
  endtask

  // Monitor: scoreboard pop on handshake, plus lock stability under backpressure
  initial begin
    bit hold;
    int hold_ch;
    int ech;
    int ecy;
    hold = 1'b0;
    hold_ch = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          checks++;
          if (!(wake_valid && (int'(wake_ch) == hold_ch))) begin
            errors++;
            $display("FAIL wake_hold actual valid=%0d ch=%0d expected valid=1 ch=%0d (cyc %0d)",
                     wake_valid, wake_ch, hold_ch, cyc);
          end
        end
        if (wake_valid && wake_ready) begin
          checks++;
          if (exp_ch.size() == 0) begin
            errors++;
            $display("FAIL unexpected_wake actual ch=%0d cyc=%0d expected none", wake_ch, cyc);
          end else begin
            ech = exp_ch.pop_front();
            ecy = exp_cyc.pop_front();
            if ((int'(wake_ch) != ech) || (cyc != ecy)) begin
              errors++;
              $display("FAIL wake actual ch=%0d cyc=%0d expected ch=%0d cyc=%0d",
                       wake_ch, cyc, ech, ecy);
            end
          end
        end
        hold    = wake_valid && !wake_ready && !cancel[wake_ch];
        hold_ch = int'(wake_ch);
      end
    end
  end

  initial begin
    int t0, t1, t2;
    rst = 1'b0; load_valid = 1'b0; load_ch = 2'd0; load_dly = 8'd0;
    load_periodic = 1'b0; cancel = 4'b0000; wake_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_wake_valid", int'(wake_valid), 0);
    chk("rst_load_ready", int'(load_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_load_ready", int'(load_ready), 1);
    repeat (50) tick();
    chk("idle_wake_valid", int'(wake_valid), 0);
    chk("idle_busy", int'(busy), 0);

    // Arbitration: all three PEND on the same edge, two rounds from last_granted=3
    for (int r = 0; r < 2; r++) begin
      arm(0, 3, 1'b0, t0);
      arm(1, 2, 1'b0, t1);
      arm(3, 1, 1'b0, t2);
      push(0, t0 + 3);
      push(1, t0 + 5);
      push(3, t0 + 7);
      wait_cyc(t0 + 10);
    end

    // No preemption: ch3 locked, higher-priority ch0 becomes PEND later
    wake_ready = 1'b0;
    arm(3, 1, 1'b0, t0);
    arm(0, 1, 1'b0, t1);
    push(3, t0 + 5);
    push(0, t0 + 7);
    wait_cyc(t0 + 3);
    @(negedge clk);
    chk("lock_ch3", int'(wake_ch), 3);
    wait_cyc(t0 + 5);
    wake_ready = 1'b1;
    wait_cyc(t0 + 9);

    // Cancel the locked channel; grant moves to ch1 a cycle later
    wake_ready = 1'b0;
    arm(0, 1, 1'b0, t0);
    arm(1, 1, 1'b0, t1);
    wait_cyc(t0 + 3);
    cancel = 4'b0001;
    @(negedge clk);
    chk("cancel_pre_valid", int'(wake_valid), 1);
    chk("cancel_pre_ch", int'(wake_ch), 0);
    tick();
    cancel = 4'b0000;
    wake_ready = 1'b1;
    push(1, t0 + 5);
    @(negedge clk);
    chk("cancel_drop_valid", int'(wake_valid), 0);
    wait_cyc(t0 + 8);
    chk("cancel_busy", int'(busy), 0);

    // Cancel and load on ch2 in the same cycle: handshake completes, load discarded
    load_valid = 1'b1; load_ch = 2'd2; load_dly = 8'd2; load_periodic = 1'b0;
    cancel = 4'b0100;
    @(negedge clk);
    chk("cancel_load_ready", int'(load_ready), 1);
    tick();
    load_valid = 1'b0;
    cancel = 4'b0000;
    @(negedge clk);
    chk("cancel_load_busy", int'(busy), 0);
    repeat (5) tick();
    chk("cancel_load_busy_later", int'(busy), 0);

    // Delay 0 behaves as 1
    arm(1, 0, 1'b0, t0);
    push(1, t0 + 1);
    wait_cyc(t0 + 4);
    chk("dly0_busy", int'(busy), 0);

    // One-shot ch1 delay 5
    arm(1, 5, 1'b0, t0);
    @(negedge clk);
    chk("oneshot_busy", int'(busy), 2);
    push(1, t0 + 5);
    wait_cyc(t0 + 12);
    chk("oneshot_done_busy", int'(busy), 0);

    // Periodic ch2 delay 3 with a 6-cycle backpressure window
    arm(2, 3, 1'b1, t0);
    push(2, t0 + 3);
    push(2, t0 + 7);
    push(2, t0 + 17);
    push(2, t0 + 21);
    wait_cyc(t0 + 8);
    wake_ready = 1'b0;
    wait_cyc(t0 + 13);
    load_valid = 1'b1; load_ch = 2'd2; load_dly = 8'd5; load_periodic = 1'b0;
    @(negedge clk);
    chk("pend_load_ready", int'(load_ready), 0);
    chk("pend_wake_ch", int'(wake_ch), 2);
    tick();
    load_valid = 1'b0;
    wait_cyc(t0 + 17);
    wake_ready = 1'b1;
    wait_cyc(t0 + 23);
    cancel = 4'b0100;
    tick();
    cancel = 4'b0000;
    @(negedge clk);
    chk("periodic_cancel_busy", int'(busy), 0);
    repeat (8) tick();

    // Async reset mid-operation: ch0 counting, ch1 pending and presented
    wake_ready = 1'b0;
    arm(0, 4, 1'b0, t0);
    arm(1, 1, 1'b0, t1);
    tick();
    @(negedge clk);
    chk("pre_reset_ch", int'(wake_ch), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_wake_valid", int'(wake_valid), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_load_ready", int'(load_ready), 0);
    tick();
    tick();
    rst = 1'b1;
    wake_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_wake_valid", int'(wake_valid), 0);
    end

    chk("scoreboard_empty", exp_ch.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
